// File: rtl/scroll_controller_pkg.sv
// Shared definitions for the HEX rotation scroll controller.
// Contents:
//   NUM_POS, SEL_W  : rotation positions and the width of the select bus
//   speed_t         : encoding of the 2-bit speed switch
//   state_t         : run/pause state encoding
//   step_period()   : clock cycles per scroll step for a given speed setting
package scroll_controller_pkg;

   localparam int NUM_POS = 6;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      SPD_1X = 2'b00,
      SPD_2X = 2'b01,
      SPD_4X = 2'b10,
      SPD_8X = 2'b11
   } speed_t;

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Cycles between automatic advances. step_div is a multiple of 8, so every
   // division here is exact.
   function automatic int step_period(input int step_div, input speed_t spd);
      case (spd)
         SPD_2X:  return step_div / 2;
         SPD_4X:  return step_div / 4;
         SPD_8X:  return step_div / 8;
         default: return step_div;
      endcase
   endfunction

endpackage

// File: rtl/scroll_controller_key_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the released->pressed transition of the
// accepted level.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (conditioner returns to "released")
//   key_n  in   raw pushbutton, active low
//   press  out  one-cycle pulse when a press has been accepted
module key_conditioner #(
   parameter int DEB_CYC = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;   // accepted level, 1 = released
   logic [CW-1:0] cnt;     // consecutive samples differing from level

   // NOTE: every flop here is assigned with <= so all of them sample the
   // values from before the clock edge; blocking assignments would collapse
   // the synchronizer stages into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == level) begin
            // Any sample agreeing with the accepted level restarts the count,
            // so bounce shorter than DEB_CYC never gets through.
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYC - 1)) begin
            cnt   <= '0;
            level <= sync_2;
            press <= ~sync_2;   // only the move to pressed (low) pulses
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/scroll_controller.sv
// Scroll controller for the 6-position HEX rotation datapath. Generates the
// select shared by the six character muxes: timed auto-scroll while running,
// single-step while paused, direction and speed from the switches.
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   run_key_n   in   raw pushbutton, active low; press toggles run/pause
//   step_key_n  in   raw pushbutton, active low; press steps once while paused
//   dir_sw      in   0 = sel counts up, 1 = sel counts down
//   speed_sw    in   step period STEP_DIV, /2, /4, /8
//   sel         out  mux select, always 0..NUM_POS-1
//   running     out  high in RUN
//   step_tick   out  one-cycle pulse whenever sel changes
//   wrap        out  one-cycle pulse when sel wraps around
module scroll_controller
   import scroll_controller_pkg::*;
#(
   parameter int STEP_DIV = 25000000,
   parameter int DEB_CYC  = 500000
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             run_key_n,
   input  logic             step_key_n,
   input  logic             dir_sw,
   input  logic [1:0]       speed_sw,
   output logic [SEL_W-1:0] sel,
   output logic             running,
   output logic             step_tick,
   output logic             wrap
);

   localparam int PW = $clog2(STEP_DIV);

   state_t           state, state_nx;
   logic [PW-1:0]    presc, presc_nx, presc_last;
   logic [SEL_W-1:0] sel_nx;
   logic             step_tick_nx;
   logic             wrap_nx;
   logic             advance;
   logic             run_press;
   logic             step_press;

   key_conditioner #(.DEB_CYC(DEB_CYC)) u_run_key (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .key_n (run_key_n),
      .press (run_press)
   );

   key_conditioner #(.DEB_CYC(DEB_CYC)) u_step_key (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .key_n (step_key_n),
      .press (step_press)
   );

   // Terminal count follows the speed switch every cycle; comparing with >=
   // lets a speed increase mid-period advance on the very next cycle.
   assign presc_last = PW'(step_period(STEP_DIV, speed_t'(speed_sw)) - 1);

   assign running = (state == RUN);

   // NOTE: every signal written below gets its default before any branch, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      presc_nx = presc;
      advance  = 1'b0;
      case (state)
         PAUSE: begin
            // Run press has priority; a simultaneous step press is dropped.
            if (run_press) begin
               state_nx = RUN;
               presc_nx = '0;
            end else if (step_press) begin
               advance = 1'b1;
            end
         end
         RUN: begin
            // Step presses are ignored while running; pausing freezes presc.
            if (run_press) begin
               state_nx = PAUSE;
            end else if (presc >= presc_last) begin
               presc_nx = '0;
               advance  = 1'b1;
            end else begin
               presc_nx = presc + PW'(1);
            end
         end
         default: state_nx = PAUSE;
      endcase
   end

   always_comb begin
      sel_nx       = sel;
      wrap_nx      = 1'b0;
      step_tick_nx = advance;
      if (advance) begin
         if (dir_sw) begin
            if (sel == '0) begin
               sel_nx  = SEL_W'(NUM_POS - 1);
               wrap_nx = 1'b1;
            end else begin
               sel_nx = sel - SEL_W'(1);
            end
         end else begin
            // >= keeps sel inside 0..NUM_POS-1 even from an unexpected value.
            if (sel >= SEL_W'(NUM_POS - 1)) begin
               sel_nx  = '0;
               wrap_nx = 1'b1;
            end else begin
               sel_nx = sel + SEL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state     <= PAUSE;
         presc     <= '0;
         sel       <= '0;
         step_tick <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         sel       <= sel_nx;
         step_tick <= step_tick_nx;
         wrap      <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller with STEP_DIV=16, DEB_CYC=4.
// Directed sequences and a table of paused step presses, plus a randomized
// phase; a behavioural model is compared against the outputs every cycle.
module tb_scroll_controller;

   localparam int STEP_DIV = 16;
   localparam int DEB_CYC  = 4;
   localparam int NPOS     = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run_key_n = 1'b1;
   logic       step_key_n = 1'b1;
   logic       dir_sw = 1'b0;
   logic [1:0] speed_sw = 2'b00;
   logic [2:0] sel;
   logic       running;
   logic       step_tick;
   logic       wrap;

   int total = 0;
   int bad   = 0;
   int n_tick = 0;
   int n_wrap = 0;
   bit chk_en = 1'b0;

   scroll_controller #(.STEP_DIV(STEP_DIV), .DEB_CYC(DEB_CYC)) dut (
      .CLOCK_50   (clk),
      .resetn     (rst_n),
      .run_key_n  (run_key_n),
      .step_key_n (step_key_n),
      .dir_sw     (dir_sw),
      .speed_sw   (speed_sw),
      .sel        (sel),
      .running    (running),
      .step_tick  (step_tick),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Key: two-stage sync, then the accepted level flips when the last DEB_CYC
   // synchronized samples all agree on a value different from it.
   typedef struct packed {
      logic               s1;
      logic               s2;
      logic               acc;
      logic               press;
      logic [DEB_CYC-1:0] hist;
      int                 n;
   } km_t;

   typedef struct packed {
      km_t  krun;
      km_t  kstep;
      int   sel;
      logic running;
      int   cnt;
      logic tick;
      logic wrap;
   } model_t;

   function automatic km_t km_reset();
      km_t k;
      k.s1 = 1'b1; k.s2 = 1'b1; k.acc = 1'b1; k.press = 1'b0;
      k.hist = '1; k.n = 0;
      return k;
   endfunction

   function automatic km_t key_step(input km_t k, input logic raw);
      km_t r = k;
      r.hist  = {k.hist[DEB_CYC-2:0], k.s2};
      r.n     = (k.n < DEB_CYC) ? k.n + 1 : k.n;
      r.press = 1'b0;
      if (r.n >= DEB_CYC && (r.hist == '0 || r.hist == '1) && k.s2 != k.acc) begin
         r.acc   = k.s2;
         r.press = (k.s2 == 1'b0);
      end
      r.s2 = k.s1;
      r.s1 = raw;
      return r;
   endfunction

   function automatic model_t model_reset();
      model_t m;
      m.krun = km_reset(); m.kstep = km_reset();
      m.sel = 0; m.running = 1'b0; m.cnt = 0; m.tick = 1'b0; m.wrap = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(input model_t m, input logic raw_run,
                                         input logic raw_step, input logic dir,
                                         input logic [1:0] spd);
      model_t r = m;
      int     p;
      bit     adv;
      p      = STEP_DIV / (1 << spd);
      adv    = 1'b0;
      r.tick = 1'b0;
      r.wrap = 1'b0;
      if (!m.running) begin
         if (m.krun.press) begin
            r.running = 1'b1;
            r.cnt     = 0;
         end else if (m.kstep.press) begin
            adv = 1'b1;
         end
      end else if (m.krun.press) begin
         r.running = 1'b0;
      end else if (m.cnt >= p - 1) begin
         r.cnt = 0;
         adv   = 1'b1;
      end else begin
         r.cnt = m.cnt + 1;
      end
      if (adv) begin
         r.tick = 1'b1;
         if (dir) begin
            r.wrap = (m.sel == 0);
            r.sel  = (m.sel + NPOS - 1) % NPOS;
         end else begin
            r.wrap = (m.sel == NPOS - 1);
            r.sel  = (m.sel + 1) % NPOS;
         end
      end
      r.krun  = key_step(m.krun, raw_run);
      r.kstep = key_step(m.kstep, raw_step);
      return r;
   endfunction

   model_t mdl = model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl <= model_reset();
      else        mdl <= model_step(mdl, run_key_n, step_key_n, dir_sw, speed_sw);
   end

   always @(negedge clk) begin
      if (chk_en)
         check("model_outputs", {26'd0, sel, running, step_tick, wrap},
               {26'd0, 3'(mdl.sel), mdl.running, mdl.tick, mdl.wrap});
      if (step_tick) n_tick++;
      if (wrap) n_wrap++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_keys(input bit r_low, input bit s_low);
      run_key_n  = ~r_low;
      step_key_n = ~s_low;
   endtask

   task automatic press_keys(input bit on_run, input bit on_step, input bit glitch);
      if (glitch) begin
         for (int g = 0; g < 2; g++) begin
            @(negedge clk); set_keys(on_run, on_step);
            @(negedge clk);
            @(negedge clk); set_keys(1'b0, 1'b0);
            @(negedge clk);
         end
      end
      @(negedge clk); set_keys(on_run, on_step);
      repeat (DEB_CYC + 4) @(negedge clk);
      set_keys(1'b0, 1'b0);
      repeat (DEB_CYC + 6) @(negedge clk);
   endtask

   task automatic wait_tick_to(input string tag, input int value, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (step_tick && sel == 3'(value)) found = 1'b1;
      end
      check(tag, found, 1);
   endtask

   // Collects n ticks, checking values, wrap position and spacing
   // (first_gap < 0 skips the spacing check on the first tick).
   task automatic expect_ticks(input string tag, input int n, input int spacing,
                               input int first_gap, input int seq[6],
                               input int wrap_at, input int budget);
      int waited = 0;
      int got = 0;
      int t_prev = 0;
      while (got < n && waited < budget) begin
         @(negedge clk);
         waited++;
         if (step_tick) begin
            check($sformatf("%s_sel%0d", tag, got), sel, seq[got]);
            check($sformatf("%s_wrap%0d", tag, got), wrap, (got == wrap_at));
            if (got > 0)
               check($sformatf("%s_gap%0d", tag, got), waited - t_prev, spacing);
            else if (first_gap >= 0)
               check($sformatf("%s_gap0", tag), waited, first_gap);
            t_prev = waited;
            got++;
         end
      end
      check({tag, "_count"}, got, n);
   endtask

   typedef struct {
      bit glitch;
      bit dir;
      int exp_sel;
      bit exp_wrap;
   } step_vec_t;

   step_vec_t tbl[9];
   int        seq_up[6];
   int        seq_dn[6];

   initial begin
      int t0, w0, hold_bad;
      bit seen;

      tbl[0] = '{1'b1, 1'b0, 3, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 4, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 5, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 5, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 4, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 5, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 0, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 1, 1'b0};
      seq_up = '{1, 2, 3, 4, 5, 0};
      seq_dn = '{2, 1, 0, 5, 0, 0};

      // Reset, then idle.
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs", {sel, running, step_tick, wrap}, 0);
      rst_n = 1'b1;
      t0 = n_tick;
      repeat (100) @(negedge clk);
      check("idle_ticks", n_tick - t0, 0);
      check("idle_sel", sel, 0);
      check("idle_running", running, 0);

      // Run at speed 00, counting up.
      press_keys(1'b1, 1'b0, 1'b0);
      check("run_running", running, 1);
      expect_ticks("up", 6, 16, -1, seq_up, 5, 200);

      // Fast reverse from sel=3.
      wait_tick_to("reach_sel3", 3, 100);
      speed_sw = 2'b11;
      dir_sw   = 1'b1;
      expect_ticks("down", 4, 2, 2, seq_dn, 3, 20);
      speed_sw = 2'b00;
      dir_sw   = 1'b0;

      // Pause at sel=2.
      wait_tick_to("reach_sel2", 2, 100);
      press_keys(1'b1, 1'b0, 1'b0);
      check("pause_running", running, 0);
      check("pause_sel", sel, 2);

      // Single-step presses while paused.
      for (int i = 0; i < 9; i++) begin
         dir_sw = tbl[i].dir;
         t0 = n_tick;
         w0 = n_wrap;
         press_keys(1'b0, 1'b1, tbl[i].glitch);
         check($sformatf("step%0d_ticks", i), n_tick - t0, 1);
         check($sformatf("step%0d_wraps", i), n_wrap - w0, tbl[i].exp_wrap);
         check($sformatf("step%0d_sel", i), sel, tbl[i].exp_sel);
         check($sformatf("step%0d_running", i), running, 0);
      end
      dir_sw = 1'b0;

      // Run and step pressed together while paused at sel=1.
      @(negedge clk); set_keys(1'b1, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (running) seen = 1'b1;
      end
      check("both_running", seen, 1);
      check("both_sel", sel, 1);
      set_keys(1'b0, 1'b0);
      hold_bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (sel != 3'd1 || step_tick) hold_bad++;
      end
      check("both_hold", hold_bad, 0);
      @(negedge clk);
      check("both_first_tc_sel", sel, 2);
      check("both_first_tc_tick", step_tick, 1);

      // Reset mid-run at sel=4.
      wait_tick_to("reach_sel4", 4, 100);
      #2 rst_n = 1'b0;
      #1 check("midreset_outputs", {sel, running, step_tick, wrap}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      t0 = n_tick;
      repeat (60) @(negedge clk);
      check("post_reset_ticks", n_tick - t0, 0);
      check("post_reset_sel", sel, 0);
      check("post_reset_running", running, 0);

      // Randomized phase against the model.
      for (int it = 0; it < 150; it++) begin
         speed_sw = 2'($urandom_range(0, 3));
         dir_sw   = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 30)) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) run_key_n = ~run_key_n;
            if ($urandom_range(0, 5) == 0) step_key_n = ~step_key_n;
         end
         if ($urandom_range(0, 40) == 0) begin
            @(negedge clk);
            #3 rst_n = 1'b0;
            @(negedge clk);
            #3 rst_n = 1'b1;
         end
      end
      set_keys(1'b0, 1'b0);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
